// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache with 4-word lines,
// word-wide memory bus and a whole-cache flush command.
module dcache #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dcache_valid,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  input  logic [3:0]  dcache_byte_enable,
  output logic        dcache_ready,
  output logic [31:0] dcache_rdata,
  input  logic        dcache_flash,
  output logic        dcache_flash_done,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [2:0] {IDLE, WB, REFILL, RESP, FL_SCAN, FL_WB, FL_DONE} state_t;

  state_t state, state_nx;
  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [NUM_LINES];
  logic [31:0] data [NUM_LINES][LINE_WORDS];
  logic [IDX_W-1:0] scan, idx, m_idx;
  logic [TAG_W-1:0] tag, m_tag;
  logic [1:0] word, beat;
  logic hit, store, last_beat, scan_last, scan_dirty, unused;
  logic [31:0] merged;

  always_comb begin
    idx        = dcache_addr[4+IDX_W-1:4];
    tag        = dcache_addr[31:4+IDX_W];
    word       = dcache_addr[3:2];
    unused     = ^dcache_addr[1:0];
    hit        = valid[idx] && tags[idx] == tag;
    store      = |dcache_byte_enable;
    scan_last  = scan == IDX_W'(NUM_LINES - 1);
    scan_dirty = valid[scan] && dirty[scan];
    last_beat  = mem_ready && beat == 2'd3;
    // Flush writebacks address the scanned line; everything else the request's line.
    m_idx      = state == FL_WB ? scan : idx;
    m_tag      = state == REFILL ? tag : tags[m_idx];
    merged     = data[idx][word];
    for (int i = 0; i < 4; i++)
      if (dcache_byte_enable[i]) merged[8*i +: 8] = dcache_wdata[8*i +: 8];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = dcache_flash ? FL_SCAN : !dcache_valid ? IDLE : hit ? RESP :
                          (valid[idx] && dirty[idx]) ? WB : REFILL;
      WB:      state_nx = last_beat ? REFILL : WB;
      REFILL:  state_nx = last_beat ? RESP : REFILL;
      FL_SCAN: state_nx = scan_dirty ? FL_WB : scan_last ? FL_DONE : FL_SCAN;
      FL_WB:   state_nx = !last_beat ? FL_WB : scan_last ? FL_DONE : FL_SCAN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_valid         = state inside {WB, REFILL, FL_WB};
    mem_we            = state inside {WB, FL_WB};
    mem_addr          = mem_valid ? {m_tag, m_idx, beat, 2'b00} : '0;
    mem_wdata         = mem_we ? data[m_idx][beat] : '0;
    dcache_ready      = state == RESP;
    dcache_rdata      = (state == RESP && !store) ? data[idx][word] : '0;
    dcache_flash_done = state == FL_DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      scan  <= '0;
      beat  <= '0;
    end else begin
      state <= state_nx;
      if (mem_valid && mem_ready) beat <= beat + 2'd1;
      if (state == IDLE) scan <= '0;
      if (state == REFILL && last_beat) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
      if (state == RESP && store) dirty[idx] <= 1'b1;
      if ((state == FL_SCAN && !scan_dirty) || (state == FL_WB && last_beat)) begin
        valid[scan] <= 1'b0;
        dirty[scan] <= 1'b0;
        scan        <= scan + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state == REFILL && mem_ready) data[idx][beat] <= mem_rdata;
    if (rst_n && state == RESP && store) data[idx][word] <= merged;
    if (rst_n && state == REFILL && last_beat) tags[idx] <= tag;
  end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: randomized bench for dcache against an architectural memory model
// (every load returns the latest stored value) plus a line-presence model for hit/miss.
module tb_dcache;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        dcache_valid = 0;
  logic [31:0] dcache_addr = 0;
  logic [31:0] dcache_wdata = 0;
  logic [3:0]  dcache_byte_enable = 0;
  logic        dcache_ready;
  logic [31:0] dcache_rdata;
  logic        dcache_flash = 0;
  logic        dcache_flash_done;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 0;
  logic [31:0] mem_rdata = 0;

  always #5 clk = ~clk;

  dcache #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .dcache_valid(dcache_valid), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_byte_enable(dcache_byte_enable), .dcache_ready(dcache_ready),
    .dcache_rdata(dcache_rdata), .dcache_flash(dcache_flash),
    .dcache_flash_done(dcache_flash_done), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } beat_t;

  int checks = 0, errors = 0;
  beat_t log_q[$], exp_q[$];
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] arch [logic [31:0]];
  bit m_valid [16], m_dirty [16];
  logic [31:0] m_tag [16];
  bit req_active = 0, cur_load = 0, flush_active = 0;
  logic [31:0] cur_exp, last_rdata;
  int last_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : init_val(a);
  endfunction

  // Memory slave: random ready, logs every completed beat.
  always @(posedge clk) begin
    #2;
    mem_ready = mem_valid && ($urandom_range(0, 99) < 60);
    mem_rdata = mem_ready ? bmem_rd(mem_addr) : $urandom;
    if (mem_ready) begin
      log_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
      if (mem_we) bmem[mem_addr] = mem_wdata;
    end
  end

  logic p_rst = 0, p_mv = 0, p_mr = 0, p_we = 0;
  logic [31:0] p_addr = 0, p_wd = 0;
  always @(negedge clk) begin
    chk("ready without request", {31'b0, dcache_ready & ~req_active}, 0);
    chk("done without flush", {31'b0, dcache_flash_done & ~flush_active}, 0);
    if (dcache_ready && req_active && cur_load) chk("load data", dcache_rdata, cur_exp);
    if (mem_valid) chk("beat alignment", {30'b0, mem_addr[1:0]}, 0);
    if (p_rst && p_mv && !p_mr) begin
      chk("held mem_valid", {31'b0, mem_valid}, 1);
      chk("held mem_we", {31'b0, mem_we}, {31'b0, p_we});
      chk("held mem_addr", mem_addr, p_addr);
      chk("held mem_wdata", mem_wdata, p_wd);
    end
    p_rst = rst_n; p_mv = mem_valid; p_mr = mem_ready; p_we = mem_we;
    p_addr = mem_addr; p_wd = mem_wdata;
  end

  task automatic cmp_beats(input string what);
    chk({what, " beat count"}, log_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < log_q.size()) begin
      chk({what, " beat dir"}, {31'b0, log_q[i].we}, {31'b0, exp_q[i].we});
      chk({what, " beat addr"}, log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) chk({what, " beat data"}, log_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int idx, n;
    logic [31:0] tg, wa, base, va, v;
    bit hit;
    idx = int'(a[7:4]);
    tg = a >> 8;
    wa = a & ~32'h3;
    base = a & ~32'hF;
    hit = m_valid[idx] && m_tag[idx] == tg;
    exp_q.delete();
    if (!hit && m_valid[idx] && m_dirty[idx])
      for (int w = 0; w < 4; w++) begin
        va = (m_tag[idx] << 8) | (idx << 4) | (w << 2);
        exp_q.push_back('{1'b1, va, arch_rd(va)});
      end
    if (!hit) for (int w = 0; w < 4; w++) exp_q.push_back('{1'b0, base + 4 * w, 32'h0});
    @(posedge clk); #1;
    log_q.delete();
    cur_load = be == 0;
    cur_exp = arch_rd(wa);
    req_active = 1;
    dcache_addr = a; dcache_wdata = wd; dcache_byte_enable = be; dcache_valid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!dcache_ready && n < 300);
    chk("request completes", {31'b0, dcache_ready}, 1);
    if (hit) chk("hit latency", n, 2);
    last_n = n;
    last_rdata = dcache_rdata;
    cmp_beats("request");
    @(posedge clk); #1;
    dcache_valid = 0;
    req_active = 0;
    if (be != 0) begin
      v = arch_rd(wa);
      for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
      arch[wa] = v;
    end
    m_dirty[idx] = hit ? (m_dirty[idx] | (be != 0)) : (be != 0);
    m_valid[idx] = 1;
    m_tag[idx] = tg;
  endtask

  task automatic do_flush();
    int n;
    logic [31:0] va;
    exp_q.delete();
    for (int idx = 0; idx < 16; idx++)
      if (m_valid[idx] && m_dirty[idx])
        for (int w = 0; w < 4; w++) begin
          va = (m_tag[idx] << 8) | (idx << 4) | (w << 2);
          exp_q.push_back('{1'b1, va, arch_rd(va)});
        end
    @(posedge clk); #1;
    log_q.delete();
    flush_active = 1;
    dcache_flash = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!dcache_flash_done && n < 3000);
    chk("flush completes", {31'b0, dcache_flash_done}, 1);
    // n counts the sample cycle itself, so n-1 cycles separate sample and done.
    if (exp_q.size() == 0) chk("clean flush cycles", n - 1, 17);
    cmp_beats("flush");
    @(posedge clk); #1;
    dcache_flash = 0;
    flush_active = 0;
    for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
  endtask

  initial begin
    int n;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      bmem[32'h100 + 4 * i] = 32'hA0 + i;
      arch[32'h100 + 4 * i] = 32'hA0 + i;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", {31'b0, dcache_ready}, 0);
    chk("reset done", {31'b0, dcache_flash_done}, 0);
    chk("reset mem_valid", {31'b0, mem_valid}, 0);
    chk("reset mem_we", {31'b0, mem_we}, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset rdata", dcache_rdata, 0);
    @(posedge clk); #1 rst_n = 1;

    do_req(32'h104, 0, 4'b0000);
    chk("cold load rdata", last_rdata, 32'hA1);
    chk("cold load beats", log_q.size(), 4);
    chk("cold first read", log_q[0].addr, 32'h100);
    do_req(32'h108, 0, 4'b0000);
    chk("hit rdata", last_rdata, 32'hA2);
    chk("hit cycles", last_n, 2);
    chk("hit no beats", log_q.size(), 0);
    do_req(32'h104, 32'h1234_5678, 4'b0011);
    chk("store hit cycles", last_n, 2);
    do_req(32'h104, 0, 4'b0000);
    chk("merged load", last_rdata, 32'h0000_5678);
    do_req(32'h1104, 0, 4'b0000);
    chk("conflict beats", log_q.size(), 8);
    chk("wb word0", log_q[0].data, 32'hA0);
    chk("wb word1", log_q[1].data, 32'h0000_5678);
    chk("wb word2", log_q[2].data, 32'hA2);
    chk("wb word3", log_q[3].data, 32'hA3);
    chk("wb addr3", log_q[3].addr, 32'h10C);
    chk("refill addr0", log_q[4].addr, 32'h1100);

    do_req(32'h1108, 32'hCAFE_F00D, 4'b1111);
    do_req(32'h54, 32'h1122_3344, 4'b1100);
    do_flush();
    chk("dirty flush beats", log_q.size(), 8);
    chk("flush first addr", log_q[0].addr, 32'h1100);
    chk("flush idx0 data", log_q[2].data, 32'hCAFE_F00D);
    chk("flush idx5 addr", log_q[4].addr, 32'h50);
    do_req(32'h1108, 0, 4'b0000);
    chk("post-flush load", last_rdata, 32'hCAFE_F00D);
    chk("post-flush miss", log_q.size(), 4);
    do_flush();
    chk("clean flush beats", log_q.size(), 0);

    // Abort a refill with reset while its third beat is on the bus.
    @(posedge clk); #1;
    log_q.delete();
    dcache_addr = 32'h2208; dcache_byte_enable = 0; dcache_valid = 1;
    cur_load = 1; cur_exp = arch_rd(32'h2208); req_active = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (log_q.size() < 2 && n < 300);
    chk("refill progress", log_q.size(), 2);
    @(posedge clk); #1;
    rst_n = 0; dcache_valid = 0; req_active = 0;
    @(posedge clk);
    @(negedge clk);
    chk("reset aborts beat", {31'b0, mem_valid}, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    arch = bmem;
    do_req(32'h2208, 0, 4'b0000);
    chk("refill after reset", log_q.size(), 4);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 19) == 0) do_flush();
      else begin
        a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
        do_req(a, $urandom, $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15)));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    do_flush();
    foreach (arch[k]) chk("memory coherent", bmem_rd(k), arch[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
